if1_stage: RTL and testbench

IF1_STAGE -- requirements
Module: if1_stage

---
 rtl/if1_stage.sv | 89 ++++++++
 tb/tb_if1_stage.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/if1_stage.sv
// IF1 fetch stage: tracks one outstanding I-cache request and queues
// returned instruction groups in a small FIFO toward decode.
module if1_stage #(
    parameter int IF0_TO_IF1_BUS_WD = 40,
    parameter int IF1_TO_ID_BUS_WD  = 168,
    parameter int FIFO_DEPTH        = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush_IF,
    input  logic                         if0_if1_valid,
    input  logic [IF0_TO_IF1_BUS_WD-1:0] if0_if1_bus,
    output logic                         IF1_ready,
    input  logic                         data_ok,
    input  logic [127:0]                 rdata,
    output logic                         if1_id_valid,
    output logic [IF1_TO_ID_BUS_WD-1:0]  if1_id_bus,
    input  logic                         id_ready
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic                         req_v;
    logic                         cancel;
    logic [IF0_TO_IF1_BUS_WD-1:0] req_info;
    logic [PW-1:0]                rptr;
    logic [PW-1:0]                wptr;
    logic [CW-1:0]                count;
    logic [IF1_TO_ID_BUS_WD-1:0]  mem [FIFO_DEPTH];

    logic [CW:0] occ;
    logic        pc_any;
    logic        accept;
    logic        push;
    logic        pop;

    // Reserve a FIFO slot for the in-flight request so a push never overflows.
    assign occ       = {1'b0, count} + {{CW{1'b0}}, req_v};
    assign IF1_ready = !cancel && (occ < (CW+1)'(FIFO_DEPTH));

    assign pc_any = |if0_if1_bus[IF0_TO_IF1_BUS_WD-1 -: 4];
    assign accept = if0_if1_valid && IF1_ready && !flush_IF && pc_any;
    assign push   = data_ok && req_v && !cancel && !flush_IF;
    assign pop    = if1_id_valid && id_ready && !flush_IF;

    assign if1_id_valid = (count != '0);
    assign if1_id_bus   = mem[rptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_v  <= 1'b0;
            cancel <= 1'b0;
            rptr   <= '0;
            wptr   <= '0;
            count  <= '0;
        end else if (flush_IF) begin
            req_v  <= 1'b0;
            rptr   <= '0;
            wptr   <= '0;
            count  <= '0;
            // A stale response still owed by the cache must be swallowed.
            cancel <= (cancel || req_v) && !data_ok;
        end else begin
            if (accept)
                req_v <= 1'b1;
            else if (push)
                req_v <= 1'b0;
            if (cancel && data_ok)
                cancel <= 1'b0;
            if (push)
                wptr <= wptr + 1'b1;
            if (pop)
                rptr <= rptr + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (accept)
            req_info <= if0_if1_bus;
        if (push)
            mem[wptr] <= IF1_TO_ID_BUS_WD'({req_info, rdata});
    end

endmodule

// File: tb/tb_if1_stage.sv
// Directed scoreboard bench for if1_stage.
module tb_if1_stage;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush_IF;
    logic         if0_if1_valid;
    logic [39:0]  if0_if1_bus;
    logic         IF1_ready;
    logic         data_ok;
    logic [127:0] rdata;
    logic         if1_id_valid;
    logic [167:0] if1_id_bus;
    logic         id_ready;

    int checks   = 0;
    int failures = 0;
    logic [167:0] exp_q [$];
    logic [39:0]  pend;

    if1_stage dut (
        .clk(clk),
        .rst(rst),
        .flush_IF(flush_IF),
        .if0_if1_valid(if0_if1_valid),
        .if0_if1_bus(if0_if1_bus),
        .IF1_ready(IF1_ready),
        .data_ok(data_ok),
        .rdata(rdata),
        .if1_id_valid(if1_id_valid),
        .if1_id_bus(if1_id_bus),
        .id_ready(id_ready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [167:0] obs,
                       input logic [167:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic logic [127:0] mk(input int k);
        logic [31:0] b;
        b = 32'h1000_0000 * k;
        return {b + 32'd4, b + 32'd3, b + 32'd2, b + 32'd1};
    endfunction

    task automatic strobe(input logic [3:0] pv, input logic [31:0] pc);
        if0_if1_bus   = {pv, 4'h0, pc};
        if0_if1_valid = 1'b1;
        tick();
        if0_if1_valid = 1'b0;
    endtask

    // Complete the pending request; bench tracks what is pending in pend.
    task automatic respond(input int k);
        rdata   = mk(k);
        data_ok = 1'b1;
        exp_q.push_back({pend, mk(k)});
        tick();
        data_ok = 1'b0;
    endtask

    task automatic pop_chk(input string tag);
        logic [167:0] e;
        chk({tag, "_valid"}, 168'(if1_id_valid), 168'(1));
        if (exp_q.size() == 0) begin
            chk({tag, "_q_empty"}, 168'(1), 168'(0));
        end else begin
            e = exp_q.pop_front();
            chk(tag, if1_id_bus, e);
        end
        id_ready = 1'b1;
        tick();
        id_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0; flush_IF = 1'b0; if0_if1_valid = 1'b0;
        if0_if1_bus = '0; data_ok = 1'b0; rdata = '0; id_ready = 1'b0;
        #12;
        chk("rst_valid", 168'(if1_id_valid), 168'(0));
        chk("rst_ready", 168'(IF1_ready), 168'(1));
        @(negedge clk); rst = 1'b1;
        tick();

        // single fetch
        pend = {4'hF, 4'h0, 32'h1c000000};
        strobe(4'hF, 32'h1c000000);
        chk("t1_ready", 168'(IF1_ready), 168'(1));
        chk("t1_not_yet", 168'(if1_id_valid), 168'(0));
        rdata = 128'h00000004_00000003_00000002_00000001;
        data_ok = 1'b1;
        exp_q.push_back({pend, rdata});
        tick();
        data_ok = 1'b0;
        pop_chk("t1_head");
        chk("t1_empty", 168'(if1_id_valid), 168'(0));

        // backpressure
        for (int k = 0; k < 3; k++) begin
            pend = {4'hF, 4'h0, 32'h1c000100 + 32'(16 * k)};
            strobe(4'hF, pend[31:0]);
            respond(k + 2);
        end
        chk("t2_ready3", 168'(IF1_ready), 168'(1));
        pend = {4'h3, 4'h0, 32'h1c000130};
        strobe(4'h3, 32'h1c000130);
        chk("t2_ready_full", 168'(IF1_ready), 168'(0));
        strobe(4'hF, 32'hdead0000);
        respond(5);
        chk("t2_ready_cnt4", 168'(IF1_ready), 168'(0));
        rdata = mk(9); data_ok = 1'b1; tick(); data_ok = 1'b0;
        for (int k = 0; k < 4; k++) pop_chk($sformatf("t2_drain%0d", k));
        chk("t2_empty", 168'(if1_id_valid), 168'(0));
        chk("t2_ready_again", 168'(IF1_ready), 168'(1));

        // flush while pending
        pend = {4'hF, 4'h0, 32'h1c000010};
        strobe(4'hF, 32'h1c000010);
        flush_IF = 1'b1; tick(); flush_IF = 1'b0;
        chk("t3_cancel_ready", 168'(IF1_ready), 168'(0));
        tick(); tick();
        rdata = mk(7); data_ok = 1'b1; tick(); data_ok = 1'b0;
        chk("t3_no_push", 168'(if1_id_valid), 168'(0));
        chk("t3_ready", 168'(IF1_ready), 168'(1));

        // same-cycle push+accept+pop
        pend = {4'hF, 4'h0, 32'h1c000200}; strobe(4'hF, pend[31:0]); respond(10);
        pend = {4'hF, 4'h0, 32'h1c000210}; strobe(4'hF, pend[31:0]); respond(11);
        pend = {4'hF, 4'h0, 32'h1c000220}; strobe(4'hF, pend[31:0]);
        chk("t4_head", if1_id_bus, exp_q.pop_front());
        exp_q.push_back({pend, mk(12)});
        rdata = mk(12); data_ok = 1'b1; id_ready = 1'b1;
        if0_if1_bus = {4'h7, 4'h2, 32'h1c000230}; if0_if1_valid = 1'b1;
        tick();
        data_ok = 1'b0; id_ready = 1'b0; if0_if1_valid = 1'b0;
        pend = {4'h7, 4'h2, 32'h1c000230};
        chk("t4_ready", 168'(IF1_ready), 168'(1));
        respond(13);
        chk("t4_full_ready", 168'(IF1_ready), 168'(1));
        pop_chk("t4_b");
        pop_chk("t4_c");
        pend = {4'hF, 4'h0, 32'h1c000240}; strobe(4'hF, pend[31:0]);
        flush_IF = 1'b1; data_ok = 1'b1; id_ready = 1'b1; rdata = mk(14);
        tick();
        flush_IF = 1'b0; data_ok = 1'b0; id_ready = 1'b0;
        exp_q.delete();
        chk("t4_flush_valid", 168'(if1_id_valid), 168'(0));
        chk("t4_flush_ready", 168'(IF1_ready), 168'(1));

        // async reset with three entries queued
        for (int k = 0; k < 3; k++) begin
            pend = {4'hF, 4'h0, 32'h1c000300 + 32'(16 * k)};
            strobe(4'hF, pend[31:0]);
            respond(k + 20);
        end
        pend = {4'hF, 4'h0, 32'h1c000330}; strobe(4'hF, pend[31:0]);
        chk("t5_pre", 168'(if1_id_valid), 168'(1));
        #2 rst = 1'b0;
        #1;
        chk("t5_async_valid", 168'(if1_id_valid), 168'(0));
        chk("t5_async_ready", 168'(IF1_ready), 168'(1));
        exp_q.delete();
        @(negedge clk); rst = 1'b1;
        tick();
        rdata = mk(30); data_ok = 1'b1; tick(); data_ok = 1'b0;
        chk("t5_stale_ok", 168'(if1_id_valid), 168'(0));
        chk("t5_ready", 168'(IF1_ready), 168'(1));

        // bubble and strobe under flush are ignored
        strobe(4'h0, 32'h1c000400);
        rdata = mk(31); data_ok = 1'b1; tick(); data_ok = 1'b0;
        chk("t6_bubble", 168'(if1_id_valid), 168'(0));
        flush_IF = 1'b1; strobe(4'hF, 32'h1c000410); flush_IF = 1'b0;
        chk("t6_flush_ready", 168'(IF1_ready), 168'(1));
        rdata = mk(32); data_ok = 1'b1; tick(); data_ok = 1'b0;
        chk("t6_flush_strobe", 168'(if1_id_valid), 168'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
